aud_sample_feeder: RTL

// Buffers signed PCM audio samples written from the APB register side and releases

---
 rtl/aud_sample_feeder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/aud_sample_feeder.sv
// aud_sample_feeder
// Buffers signed PCM samples pushed from the register side in a small FIFO and
// releases them to the PWM core at a programmable sample rate. Playback waits
// until the FIFO holds PRIME_LVL samples, then pops one sample every div_i+1
// clocks. A period that ends with an empty FIFO raises a sticky underrun flag
// and leaves the previous sample in place.
//
// Ports
//   pclk_i          clock, rising edge
//   preset_i        synchronous active-high reset
//   en_i            playback enable level; low returns to idle and silences output
//   wr_valid_i      push request
//   wr_data_i       sample to push
//   wr_ready_o      FIFO can accept a push (not full)
//   div_i           sample period minus one, in clocks
//   sample_o        current sample for the PWM core
//   sample_stb_o    one-cycle pulse when sample_o changes
//   level_o         samples stored (0..DEPTH)
//   full_o/empty_o  FIFO status
//   underrun_o      sticky underrun flag
//   clr_underrun_i  clears underrun_o (a simultaneous new underrun wins)

module aud_sample_feeder #(
  parameter int SAMPLE_W  = 16,
  parameter int DEPTH     = 16,
  parameter int DIV_W     = 16,
  parameter int PRIME_LVL = 4
) (
  input  logic                       pclk_i,
  input  logic                       preset_i,
  input  logic                       en_i,
  input  logic                       wr_valid_i,
  input  logic signed [SAMPLE_W-1:0] wr_data_i,
  output logic                       wr_ready_o,
  input  logic        [DIV_W-1:0]    div_i,
  output logic signed [SAMPLE_W-1:0] sample_o,
  output logic                       sample_stb_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       underrun_o,
  input  logic                       clr_underrun_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    PLAY  = 2'd2
  } state_t;

  state_t                      state;
  logic signed [SAMPLE_W-1:0]  mem [DEPTH];
  logic        [AW-1:0]        wr_ptr;
  logic        [AW-1:0]        rd_ptr;
  logic        [DIV_W-1:0]     cnt_p0;
  logic                        vld_p1;
  logic                        push;
  logic                        pop;
  logic                        underrun_set;

  assign full_o     = (level_o == LW'(DEPTH));
  assign empty_o    = (level_o == '0);
  assign wr_ready_o = ~full_o;

  // A push while full is dropped, so a full FIFO never overwrites its head.
  assign push = wr_valid_i & ~full_o;

  // Period-end tick from stage p1 either pops the head or records an underrun.
  assign pop          = (state == PLAY) & en_i & vld_p1 & ~empty_o;
  assign underrun_set = (state == PLAY) & en_i & vld_p1 & empty_o;

  // Sample storage: data only, no reset needed.
  always_ff @(posedge pclk_i) begin
    if (push) begin
      mem[wr_ptr] <= wr_data_i;
    end
  end

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level_o      <= '0;
      cnt_p0       <= '0;
      vld_p1       <= 1'b0;
      sample_o     <= '0;
      sample_stb_o <= 1'b0;
      underrun_o   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      case ({push, pop})
        2'b10:   level_o <= level_o + LW'(1);
        2'b01:   level_o <= level_o - LW'(1);
        default: level_o <= level_o;
      endcase

      if (underrun_set) begin
        underrun_o <= 1'b1;
      end else if (clr_underrun_i) begin
        underrun_o <= 1'b0;
      end

      sample_stb_o <= 1'b0;
      vld_p1       <= 1'b0;

      if (!en_i) begin
        state  <= IDLE;
        cnt_p0 <= '0;
        // Drive the PWM to silence once; no strobe if already silent.
        if (sample_o != '0) begin
          sample_o     <= '0;
          sample_stb_o <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            state <= PRIME;
          end
          PRIME: begin
            if (level_o >= LW'(PRIME_LVL)) begin
              state  <= PLAY;
              cnt_p0 <= div_i;
            end
          end
          PLAY: begin
            // Stage p0: period counter; reaching zero reloads and raises the tick.
            if (cnt_p0 == '0) begin
              cnt_p0 <= div_i;
              vld_p1 <= 1'b1;
            end else begin
              cnt_p0 <= cnt_p0 - DIV_W'(1);
            end
            // Stage p2: tick from p1 pops the head into the output register.
            if (pop) begin
              sample_o     <= mem[rd_ptr];
              sample_stb_o <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
